// File: rtl/fp_addsub_sched.sv
// Round-robin scheduler/sequencer for the combinational FP add/sub datapath.
// Optional counters: define FP_ADDSUB_SCHED_STATS_EN for stat_ops/stat_errs.
module fp_addsub_sched #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [63:0] req_a,
  input  logic [63:0] req_b,
  input  logic [1:0]  req_op,
  output logic        dp_sign1,
  output logic        dp_sign2,
  output logic [7:0]  dp_exp1,
  output logic [7:0]  dp_exp2,
  output logic [22:0] dp_sig1,
  output logic [22:0] dp_sig2,
  output logic        dp_opcode,
  input  logic [31:0] dp_fp_out,
  input  logic [2:0]  dp_error,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_result,
  output logic [2:0]  rsp_error
`ifdef FP_ADDSUB_SCHED_STATS_EN
  ,
  output logic [15:0] stat_ops,
  output logic [15:0] stat_errs
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYCLES - 1);

  state_t      state;
  logic [3:0]  cnt;
  logic        rr_last;
  logic        cur_id;
  logic [1:0]  grant;
  logic        sel;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        op_sub;

  // Prefer the requester that did not win last; fall back to the other.
  always_comb begin
    grant = 2'b00;
    if (rr_last) begin
      if (req_valid[0])      grant = 2'b01;
      else if (req_valid[1]) grant = 2'b10;
    end else begin
      if (req_valid[1])      grant = 2'b10;
      else if (req_valid[0]) grant = 2'b01;
    end
  end

  assign req_ready = (state == IDLE) ? grant : 2'b00;
  assign sel       = grant[1];
  assign op_a      = sel ? req_a[63:32] : req_a[31:0];
  assign op_b      = sel ? req_b[63:32] : req_b[31:0];
  assign op_sub    = sel ? req_op[1] : req_op[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      rr_last    <= 1'b1;
      cur_id     <= 1'b0;
      dp_sign1   <= 1'b0;
      dp_sign2   <= 1'b0;
      dp_exp1    <= 8'd0;
      dp_exp2    <= 8'd0;
      dp_sig1    <= 23'd0;
      dp_sig2    <= 23'd0;
      dp_opcode  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= 32'd0;
      rsp_error  <= 3'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (|req_valid) begin
            dp_sign1  <= op_a[31];
            dp_exp1   <= op_a[30:23];
            dp_sig1   <= op_a[22:0];
            dp_sign2  <= op_b[31];
            dp_exp2   <= op_b[30:23];
            dp_sig2   <= op_b[22:0];
            dp_opcode <= op_sub;
            cur_id    <= sel;
            rr_last   <= sel;
            cnt       <= 4'd0;
            state     <= HOLD;
          end
        end
        HOLD: state <= WAIT;
        WAIT: begin
          if (cnt == CNT_LAST) begin
            rsp_result <= dp_fp_out;
            rsp_error  <= dp_error;
            rsp_id     <= cur_id;
            rsp_valid  <= 1'b1;
            state      <= DONE;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
      endcase
    end
  end

`ifdef FP_ADDSUB_SCHED_STATS_EN
  logic rsp_fire;
  assign rsp_fire = (state == DONE) && rsp_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_ops  <= 16'd0;
      stat_errs <= 16'd0;
    end else if (rsp_fire) begin
      if (stat_ops != 16'hFFFF)
        stat_ops <= stat_ops + 16'd1;
      if ((rsp_error != 3'd0) && (stat_errs != 16'hFFFF))
        stat_errs <= stat_errs + 16'd1;
    end
  end
`endif

endmodule
